tree_builder_rt: RTL and testbench
==================================

Name: tree_builder_rt

Overview:
- Runtime, sequential successor to the elaboration-time tree generator.
- Accepts identifier paths as a beat stream and walks a register-held node tree, one level per cycle.
- Insert mode adds missing nodes; lookup mode only reports how far the path exists.
- Sits between the message-descriptor loader and downstream field decoders, which read nodes through a registered read port.

Parameters:
- ID_W, 8, identifier width; id 0 is reserved as "unused".
- ADDR_W, 8, node address width.
- NUM_NODES, 64, node storage depth including root (must be ≤ 2**ADDR_W).
- MAX_CHILDREN, 4, child slots per node.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous tree wipe; takes priority over stream activity
- s_valid  in  1  path beat valid
- s_ready  out  1  path beat accept
- s_id  in  ID_W  identifier for current level
- s_last  in  1  final beat of path
- s_mode  in  1  0=lookup, 1=insert; sampled on first beat of path only
- r_valid  out  1  result valid
- r_ready  in  1  result accept
- r_addr  out  ADDR_W  deepest matched or created node
- r_found  out  1  whole path pre-existed
- r_err  out  2  0=OK, 1=TREE_FULL, 2=CHILD_FULL, 3=ZERO_ID
- rd_addr  in  ADDR_W  node read address
- rd_id  out  ID_W  node id, registered 1 cycle
- rd_parent  out  ADDR_W  parent address, registered 1 cycle
- rd_children  out  ADDR_W*MAX_CHILDREN  child slots, slot k at [k*ADDR_W +: ADDR_W], registered
- node_count  out  ADDR_W+1  allocated nodes including root

Behaviour:
- Reset/clear:
  - All nodes zeroed; root is node 0 with id 0.
  - node_count=1, free_ptr=1, cur=0.
  - State WALK; s_ready=1; r_valid=0; r_addr, r_found, r_err = 0; rd_* = 0.
- Child slot value 0 means empty; root is never a child.
- A slot matches only if it is non-zero and node[slot].id==s_id. All MAX_CHILDREN slots are compared in parallel within one cycle.
- WALK, beat accepted (s_valid & s_ready):
  - id==0: err=ZERO_ID, no tree change.
  - Match: cur←matched child.
  - No match, lookup mode: found=0, no error, path stops.
  - No match, insert mode, free_ptr==NUM_NODES: err=TREE_FULL.
  - No match, insert mode, no empty slot: err=CHILD_FULL.
  - No match, insert mode, otherwise:
    - Write the lowest empty slot of cur ← free_ptr.
    - node[free_ptr] ← {parent=cur, children=0, id=s_id}.
    - cur←free_ptr, free_ptr++, node_count++, path_new←1.
  - Both writes complete in the same cycle.
- Path termination:
  - If the beat ends the path (s_last, error, or lookup miss) and s_last=1, go to RESP.
  - If it ends the path without s_last, go to DRAIN.
- DRAIN: s_ready=1; beats are consumed with no effect until s_last, then go to RESP.
- RESP:
  - s_ready=0, r_valid=1.
  - r_addr=cur (deepest valid node).
  - r_found = !path_new & no error & no lookup miss.
  - r_err as latched.
  - Outputs hold stable until r_ready; on handshake go to WALK with cur=0, path_new=0, err=0.
- Latency: one cycle per beat; r_valid rises the cycle after the s_last beat is accepted.
- A path with zero beats is impossible; s_last on the first beat means a single-level path.
- Read port: rd_* ← node[rd_addr] every cycle.
  - A read and a write to the same node in the same cycle returns the old contents.
  - rd_addr ≥ NUM_NODES returns 0.
- clear asserted mid-path: tree wiped, state WALK, r_valid dropped; the rest of the in-flight path is treated as a new path.
- rst asserted mid-path: same as clear, but asynchronous.
- Errors never partially modify the tree; nodes created at earlier levels of the same path remain.

Decomposition:
- tree_pkg (extended): ADDR_W-parametrised node struct {parent, children[MAX_CHILDREN], id}, r_err enum, mode enum, and a SLICE/ADD-style helper for packed child lists.
- Sub-module tree_child_match: combinational; takes a node's child list, the child ids and s_id; outputs hit, hit_addr, free_hit and lowest free slot index.

Test Plan:
- Insert [5,7] into empty tree → node1 {id5, par0}, node2 {id7, par1}, r_addr=2, r_found=0, r_err=0, node_count=3; rd_addr=0 gives rd_children slot0=1.
- Repeat insert [5,7], then lookup [5,7] → both r_addr=2, r_found=1, node_count stays 3.
- Lookup [5,9,3] → miss at level 2; beat 3 drained; r_addr=1, r_found=0, r_err=0, tree unchanged.
- MAX_CHILDREN=4: insert single-beat paths 1, 2, 3, 4, 6 → fifth gives r_err=2 (CHILD_FULL), r_addr=0, node_count=5.
- NUM_NODES=4: insert [1,2,3,4] → r_err=1 (TREE_FULL) on beat 4, r_addr=3, nodes 1–3 remain; then insert [0] → r_err=3 (ZERO_ID).
- Hold r_ready=0 for 5 cycles → r_valid and r_* held stable, s_ready=0. Assert rst mid-path [8,9] → all outputs at reset values, node_count=1, next path starts at root.

Source files
------------

// File: rtl/tree_pkg.sv
// Shared types for the runtime tree builder: error codes, path mode, walker states.
// Also provides the index-width helper used to size slot and node selectors.
package tree_pkg;

  typedef enum logic [1:0] {
    ERR_OK         = 2'd0,
    ERR_TREE_FULL  = 2'd1,
    ERR_CHILD_FULL = 2'd2,
    ERR_ZERO_ID    = 2'd3
  } err_e;

  typedef enum logic {
    MODE_LOOKUP = 1'b0,
    MODE_INSERT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_WALK  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Selector width for n entries; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tree_child_match.sv
// Compares every child slot of one node against an identifier in parallel.
// Purely combinational: no latency, no flow control.
module tree_child_match #(
  parameter int ID_W         = 8,
  parameter int ADDR_W       = 8,
  parameter int MAX_CHILDREN = 4,
  parameter int IDX_W        = 2
) (
  input  logic [MAX_CHILDREN-1:0][ADDR_W-1:0] children,
  input  logic [MAX_CHILDREN-1:0][ID_W-1:0]   child_ids,
  input  logic [ID_W-1:0]                     s_id,
  output logic                                hit,
  output logic [ADDR_W-1:0]                   hit_addr,
  output logic                                free_hit,
  output logic [IDX_W-1:0]                    free_idx
);

  // Descending scan so the lowest empty slot wins; sibling ids are unique.
  always_comb begin
    hit      = 1'b0;
    hit_addr = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int k = MAX_CHILDREN - 1; k >= 0; k--) begin
      if (children[k] != '0 && child_ids[k] == s_id) begin
        hit      = 1'b1;
        hit_addr = children[k];
      end
      if (children[k] == '0) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/tree_builder_rt.sv
// Walks/extends a register-held id tree one path beat per cycle; result valid the cycle after s_last.
// Backpressure: s_ready drops while a result waits for r_ready; read port is registered, 1 cycle.
module tree_builder_rt
  import tree_pkg::*;
#(
  parameter int ID_W         = 8,
  parameter int ADDR_W       = 8,
  parameter int NUM_NODES    = 64,
  parameter int MAX_CHILDREN = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [ID_W-1:0]                  s_id,
  input  logic                             s_last,
  input  logic                             s_mode,
  output logic                             r_valid,
  input  logic                             r_ready,
  output logic [ADDR_W-1:0]                r_addr,
  output logic                             r_found,
  output logic [1:0]                       r_err,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [ID_W-1:0]                  rd_id,
  output logic [ADDR_W-1:0]                rd_parent,
  output logic [ADDR_W*MAX_CHILDREN-1:0]   rd_children,
  output logic [ADDR_W:0]                  node_count
);

  localparam int              IDX_W     = idx_w(MAX_CHILDREN);
  localparam int              NIDX_W    = idx_w(NUM_NODES);
  localparam logic [ADDR_W:0] NODES_LIM = (ADDR_W + 1)'(NUM_NODES);

  typedef logic [MAX_CHILDREN-1:0][ADDR_W-1:0] child_list_t;

  typedef struct packed {
    logic [ADDR_W-1:0] parent;
    child_list_t       children;
    logic [ID_W-1:0]   id;
  } node_t;

  node_t nodes [NUM_NODES];

  state_e            state, state_n;
  err_e              err, err_n;
  mode_e             mode_q, mode_n, mode_eff;
  logic [ADDR_W-1:0] cur, cur_n;
  logic [ADDR_W:0]   count_q, count_n;  // also the next free node address
  logic              path_new, path_new_n;
  logic              miss, miss_n;
  logic              first, first_n;
  logic              beat, ends, do_ins;

  child_list_t                          cur_children;
  logic [MAX_CHILDREN-1:0][ID_W-1:0]    child_ids;
  logic                                 hit, free_hit;
  logic [ADDR_W-1:0]                    hit_addr;
  logic [IDX_W-1:0]                     free_idx;

  always_comb begin
    cur_children = nodes[cur[NIDX_W-1:0]].children;
    for (int k = 0; k < MAX_CHILDREN; k++) begin
      child_ids[k] = nodes[cur_children[k][NIDX_W-1:0]].id;
    end
  end

  tree_child_match #(
    .ID_W        (ID_W),
    .ADDR_W      (ADDR_W),
    .MAX_CHILDREN(MAX_CHILDREN),
    .IDX_W       (IDX_W)
  ) u_match (
    .children (cur_children),
    .child_ids(child_ids),
    .s_id     (s_id),
    .hit      (hit),
    .hit_addr (hit_addr),
    .free_hit (free_hit),
    .free_idx (free_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_WALK;
      err      <= ERR_OK;
      mode_q   <= MODE_LOOKUP;
      cur      <= '0;
      count_q  <= (ADDR_W + 1)'(1);
      path_new <= 1'b0;
      miss     <= 1'b0;
      first    <= 1'b1;
    end else if (clear) begin
      state    <= ST_WALK;
      err      <= ERR_OK;
      mode_q   <= MODE_LOOKUP;
      cur      <= '0;
      count_q  <= (ADDR_W + 1)'(1);
      path_new <= 1'b0;
      miss     <= 1'b0;
      first    <= 1'b1;
    end else begin
      state    <= state_n;
      err      <= err_n;
      mode_q   <= mode_n;
      cur      <= cur_n;
      count_q  <= count_n;
      path_new <= path_new_n;
      miss     <= miss_n;
      first    <= first_n;
    end
  end

  always_comb begin
    state_n    = state;
    err_n      = err;
    mode_n     = mode_q;
    cur_n      = cur;
    count_n    = count_q;
    path_new_n = path_new;
    miss_n     = miss;
    first_n    = first;
    do_ins     = 1'b0;
    ends       = 1'b0;
    s_ready    = (state != ST_RESP);
    r_valid    = (state == ST_RESP);
    beat       = s_valid & s_ready;
    // Mode is only taken from the first beat of a path.
    mode_eff   = first ? mode_e'(s_mode) : mode_q;

    case (state)
      ST_WALK: begin
        if (beat) begin
          first_n = 1'b0;
          mode_n  = mode_eff;
          if (s_id == '0) begin
            err_n = ERR_ZERO_ID;
            ends  = 1'b1;
          end else if (hit) begin
            cur_n = hit_addr;
          end else if (mode_eff == MODE_LOOKUP) begin
            miss_n = 1'b1;
            ends   = 1'b1;
          end else if (count_q == NODES_LIM) begin
            err_n = ERR_TREE_FULL;
            ends  = 1'b1;
          end else if (!free_hit) begin
            err_n = ERR_CHILD_FULL;
            ends  = 1'b1;
          end else begin
            do_ins     = 1'b1;
            cur_n      = count_q[ADDR_W-1:0];
            count_n    = count_q + 1'b1;
            path_new_n = 1'b1;
          end
          if (s_last) begin
            state_n = ST_RESP;
          end else if (ends) begin
            state_n = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (beat && s_last) begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_ready) begin
          state_n    = ST_WALK;
          cur_n      = '0;
          path_new_n = 1'b0;
          miss_n     = 1'b0;
          err_n      = ERR_OK;
          first_n    = 1'b1;
        end
      end
      default: state_n = ST_WALK;
    endcase
  end

  // Parent slot update and new node fill land on the same edge; reads see pre-edge contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nodes       <= '{default: '0};
      rd_id       <= '0;
      rd_parent   <= '0;
      rd_children <= '0;
    end else if (clear) begin
      nodes       <= '{default: '0};
      rd_id       <= '0;
      rd_parent   <= '0;
      rd_children <= '0;
    end else begin
      if (do_ins) begin
        nodes[cur[NIDX_W-1:0]].children[free_idx] <= count_q[ADDR_W-1:0];
        nodes[count_q[NIDX_W-1:0]] <= '{parent: cur, children: '0, id: s_id};
      end
      if ({1'b0, rd_addr} < NODES_LIM) begin
        rd_id       <= nodes[rd_addr[NIDX_W-1:0]].id;
        rd_parent   <= nodes[rd_addr[NIDX_W-1:0]].parent;
        rd_children <= nodes[rd_addr[NIDX_W-1:0]].children;
      end else begin
        rd_id       <= '0;
        rd_parent   <= '0;
        rd_children <= '0;
      end
    end
  end

  assign r_addr     = cur;
  assign r_err      = err;
  assign r_found    = r_valid & ~path_new & (err == ERR_OK) & ~miss;
  assign node_count = count_q;

endmodule

// File: tb/tb_tree_builder_rt.sv
// Directed and random paths into a 64-node and a 4-node tree, checked against an array-based tree model.
module tb_tree_builder_rt;

  logic        clk = 1'b0;
  logic        rst, clear, s_valid, s_last, s_mode, r_ready, sel;
  logic [7:0]  s_id, rd_addr;

  logic        s_ready0, r_valid0, r_found0, s_ready1, r_valid1, r_found1;
  logic [7:0]  r_addr0, r_addr1, rd_id0, rd_id1, rd_parent0, rd_parent1;
  logic [1:0]  r_err0, r_err1;
  logic [31:0] rd_children0, rd_children1;
  logic [8:0]  node_count0, node_count1;

  logic        m_s_ready, m_r_valid, m_r_found;
  logic [7:0]  m_r_addr, m_rd_id, m_rd_parent;
  logic [1:0]  m_r_err;
  logic [31:0] m_rd_children;
  logic [8:0]  m_node_count;

  assign m_s_ready     = sel ? s_ready1     : s_ready0;
  assign m_r_valid     = sel ? r_valid1     : r_valid0;
  assign m_r_found     = sel ? r_found1     : r_found0;
  assign m_r_addr      = sel ? r_addr1      : r_addr0;
  assign m_r_err       = sel ? r_err1       : r_err0;
  assign m_rd_id       = sel ? rd_id1       : rd_id0;
  assign m_rd_parent   = sel ? rd_parent1   : rd_parent0;
  assign m_rd_children = sel ? rd_children1 : rd_children0;
  assign m_node_count  = sel ? node_count1  : node_count0;

  always #5 clk = ~clk;

  tree_builder_rt dut0 (
    .clk(clk), .rst(rst), .clear(clear & ~sel),
    .s_valid(s_valid & ~sel), .s_ready(s_ready0), .s_id(s_id), .s_last(s_last), .s_mode(s_mode),
    .r_valid(r_valid0), .r_ready(r_ready & ~sel), .r_addr(r_addr0), .r_found(r_found0), .r_err(r_err0),
    .rd_addr(rd_addr), .rd_id(rd_id0), .rd_parent(rd_parent0), .rd_children(rd_children0),
    .node_count(node_count0)
  );

  tree_builder_rt #(.NUM_NODES(4)) dut1 (
    .clk(clk), .rst(rst), .clear(clear & sel),
    .s_valid(s_valid & sel), .s_ready(s_ready1), .s_id(s_id), .s_last(s_last), .s_mode(s_mode),
    .r_valid(r_valid1), .r_ready(r_ready & sel), .r_addr(r_addr1), .r_found(r_found1), .r_err(r_err1),
    .rd_addr(rd_addr), .rd_id(rd_id1), .rd_parent(rd_parent1), .rd_children(rd_children1),
    .node_count(node_count1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference tree: per node id, parent and children in insertion order.
  int m_id  [2][64];
  int m_par [2][64];
  int m_kid [2][64][4];
  int m_nk  [2][64];
  int m_cnt [2];
  int lim   [2];
  int path_q[$];
  int rd_trace[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int d);
    for (int n = 0; n < 64; n++) begin
      m_id[d][n] = 0; m_par[d][n] = 0; m_nk[d][n] = 0;
      for (int k = 0; k < 4; k++) m_kid[d][n][k] = 0;
    end
    m_cnt[d] = 1;
  endtask

  task automatic model_path(input int d, input bit ins, output int e_addr, output int e_found, output int e_err);
    int cur, hit, created, missed;
    cur = 0; created = 0; missed = 0; e_err = 0;
    for (int i = 0; i < path_q.size(); i++) begin
      hit = -1;
      if (path_q[i] == 0) begin e_err = 3; break; end
      for (int k = 0; k < m_nk[d][cur]; k++)
        if (m_id[d][m_kid[d][cur][k]] == path_q[i]) hit = m_kid[d][cur][k];
      if (hit >= 0) cur = hit;
      else if (!ins) begin missed = 1; break; end
      else if (m_cnt[d] == lim[d]) begin e_err = 1; break; end
      else if (m_nk[d][cur] == 4) begin e_err = 2; break; end
      else begin
        m_id[d][m_cnt[d]]  = path_q[i];
        m_par[d][m_cnt[d]] = cur;
        m_kid[d][cur][m_nk[d][cur]] = m_cnt[d];
        m_nk[d][cur]++;
        cur = m_cnt[d];
        m_cnt[d]++;
        created = 1;
      end
    end
    e_addr  = cur;
    e_found = (!created && e_err == 0 && !missed) ? 1 : 0;
  endtask

  task automatic run_path(input bit ins, input int hold);
    int e_addr, e_found, e_err, guard;
    model_path(sel ? 1 : 0, ins, e_addr, e_found, e_err);
    for (int i = 0; i < path_q.size(); i++) begin
      s_valid = 1'b1;
      s_id    = 8'(path_q[i]);
      s_last  = (i == path_q.size() - 1);
      s_mode  = (i == 0) ? ins : 1'($urandom_range(0, 1));
      guard = 0;
      while (!m_s_ready && guard < 20) begin @(negedge clk); guard++; end
      check("s_ready_beat", m_s_ready, 1);
      @(posedge clk); @(negedge clk);
      rd_trace[i] = int'(m_rd_id);
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("r_valid_latency", m_r_valid, 1);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("hold_r_valid", m_r_valid, 1);
      check("hold_s_ready", m_s_ready, 0);
      check("hold_r_addr", m_r_addr, e_addr);
      check("hold_r_found", m_r_found, e_found);
    end
    check("r_addr", m_r_addr, e_addr);
    check("r_found", m_r_found, e_found);
    check("r_err", m_r_err, e_err);
    r_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    r_ready = 1'b0;
    check("r_valid_drop", m_r_valid, 0);
    check("node_count", m_node_count, m_cnt[sel ? 1 : 0]);
  endtask

  task automatic check_tree(input int d);
    logic [31:0] exp_ch;
    for (int n = 0; n < lim[d]; n++) begin
      rd_addr = 8'(n);
      @(posedge clk); @(negedge clk);
      exp_ch = '0;
      for (int k = 0; k < 4; k++) exp_ch[k*8 +: 8] = 8'(m_kid[d][n][k]);
      check("rd_id", m_rd_id, m_id[d][n]);
      check("rd_parent", m_rd_parent, m_par[d][n]);
      check("rd_children", m_rd_children, exp_ch);
    end
    rd_addr = (d == 0) ? 8'd200 : 8'd4;
    @(posedge clk); @(negedge clk);
    check("rd_out_of_range", {m_rd_id, m_rd_parent, m_rd_children}, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s_ready"}, m_s_ready, 1);
    check({tag, "_r_valid"}, m_r_valid, 0);
    check({tag, "_r_outs"}, {m_r_addr, m_r_found, m_r_err}, 0);
    check({tag, "_node_count"}, m_node_count, 1);
  endtask

  initial begin
    lim[0] = 64; lim[1] = 4;
    model_clear(0); model_clear(1);
    rst = 1'b1; clear = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_mode = 1'b0;
    s_id = '0; r_ready = 1'b0; rd_addr = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_rd", {m_rd_id, m_rd_parent, m_rd_children}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Insert [5,7]; read node 1 while it is being created.
    rd_addr = 8'd1;
    path_q = '{5, 7};
    run_path(1'b1, 0);
    check("rd_same_cycle_old", rd_trace[0], 0);
    check("rd_after_write", rd_trace[1], 5);
    check_tree(0);

    run_path(1'b1, 0);
    run_path(1'b0, 0);

    path_q = '{5, 9, 3};
    run_path(1'b0, 0);
    check_tree(0);

    // Fill the root's child slots from an empty tree.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    model_clear(0);
    check_idle("clear");
    for (int i = 0; i < 5; i++) begin
      path_q = '{(i < 4) ? i + 1 : 6};
      run_path(1'b1, 0);
    end
    check_tree(0);

    // Small tree runs out of nodes, then a zero id.
    sel = 1'b1;
    path_q = '{1, 2, 3, 4};
    run_path(1'b1, 0);
    path_q = '{0};
    run_path(1'b1, 0);
    check_tree(1);

    // Clear while a result is pending drops r_valid.
    s_valid = 1'b1; s_id = 8'd9; s_last = 1'b1; s_mode = 1'b0;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("pre_clear_r_valid", m_r_valid, 1);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    model_clear(1);
    check_idle("clear_resp");

    // Result held under backpressure.
    sel = 1'b0;
    path_q = '{8};
    run_path(1'b1, 5);

    // Asynchronous reset in the middle of path [8,9].
    s_valid = 1'b1; s_id = 8'd8; s_last = 1'b0; s_mode = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle("rst_mid");
    check("rst_mid_rd", {m_rd_id, m_rd_parent, m_rd_children}, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear(0); model_clear(1);
    @(negedge clk);
    path_q = '{9};
    run_path(1'b0, 0);
    run_path(1'b1, 0);

    // Random paths against the model, with occasional zero ids.
    for (int p = 0; p < 70; p++) begin
      int len;
      path_q.delete();
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        path_q.push_back(($urandom_range(0, 12) == 0) ? 0 : int'($urandom_range(1, 5)));
      run_path(1'($urandom_range(0, 3) != 0), $urandom_range(0, 2));
    end
    check_tree(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, limit 2000000");
    $fatal(1, "timeout");
  end

endmodule
